parallel_to_serial: RTL

Converts one OFDM symbol, presented as a DEPTH-wide vector of signed samples (IFFT output side of the baseband transmitter), into a serial stream of one sample per clock. It is the inverse of the serial-to-parallel stage: element 0 of the vector is emitted first, so a serial→parallel→serial round trip preserves sample order. It optionally prepends a cyclic prefix and supports gapless back-to-back symbols.

---
 rtl/ofdm_pkg.sv | 7 +
 rtl/parallel_to_serial.sv | 94 +++++++++
 2 files changed

// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared OFDM baseband constants, sample type and parallel-to-serial FSM states
package ofdm_pkg;
  localparam int DEF_REG_WIDTH = 32;
  localparam int DEF_DEPTH = 8;
  typedef logic signed [DEF_REG_WIDTH-1:0] sample_t;
  typedef enum logic [1:0] {IDLE, CP, DATA} p2s_state_t;
endpackage

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: emits one OFDM symbol (DEPTH samples, element 0 first) as one sample per clock
//   optional cyclic prefix under `P2S_CYCLIC_PREFIX_EN (last CP_LEN samples sent ahead of the symbol)
//   clk, rst (async, active-low); in_valid/parallel_in/in_ready load side (in_ready combinational);
//   serial_out/out_valid/sym_start/sym_last registered stream side, no backpressure
module parallel_to_serial
  import ofdm_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CP_LEN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [REG_WIDTH*DEPTH-1:0] parallel_in,
  output logic                       in_ready,
  output logic [REG_WIDTH-1:0]       serial_out,
  output logic                       out_valid,
  output logic                       sym_start,
  output logic                       sym_last
);
  localparam int CW = $clog2(DEPTH + CP_LEN) + 1;
  localparam int IW = $clog2(DEPTH);
`ifdef P2S_CYCLIC_PREFIX_EN
  localparam int SYM_LEN = DEPTH + CP_LEN;
`else
  localparam int SYM_LEN = DEPTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(SYM_LEN - 1);
  p2s_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, pos;
  logic [IW-1:0] idx;
  logic [REG_WIDTH-1:0] in_arr [DEPTH];
  logic [REG_WIDTH-1:0] buf_q [DEPTH];
  logic [REG_WIDTH-1:0] serial_d;
  logic valid_d, start_d, last_d, xfer;
  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign in_arr[i] = parallel_in[i*REG_WIDTH +: REG_WIDTH];
  end
  assign in_ready = rst && (state_q == IDLE || sym_last);
  assign xfer = in_valid && in_ready;
  // position within the symbol of the sample to show next cycle; a transfer restarts at 0
  assign pos = xfer ? '0 : cnt_q + 1'b1;
`ifdef P2S_CYCLIC_PREFIX_EN
  logic in_cp;
  assign in_cp = pos < CW'(CP_LEN);
  assign idx = in_cp ? IW'(pos + CW'(DEPTH - CP_LEN)) : IW'(pos - CW'(CP_LEN));
`else
  assign idx = IW'(pos);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    serial_d = serial_out;
    valid_d = out_valid;
    start_d = 1'b0;
    last_d = 1'b0;
    if (xfer || (state_q != IDLE && !sym_last)) begin
      cnt_d = pos;
      // the first sample comes straight from the input so it lands on the transfer edge
      serial_d = xfer ? in_arr[idx] : buf_q[idx];
      valid_d = 1'b1;
      start_d = xfer;
      last_d = pos == LAST;
`ifdef P2S_CYCLIC_PREFIX_EN
      state_d = in_cp ? CP : DATA;
`else
      state_d = DATA;
`endif
    end else if (state_q != IDLE) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      buf_q <= '{default: '0};
      serial_out <= '0;
      out_valid <= 1'b0;
      sym_start <= 1'b0;
      sym_last <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (xfer) buf_q <= in_arr;
      serial_out <= serial_d;
      out_valid <= valid_d;
      sym_start <= start_d;
      sym_last <= last_d;
    end
  end
endmodule
